vpu_dst_port: RTL and testbench

- Consumer side of the ALU result interface: captures each result_o/done_o pair from a VPU ALU unit and buffers it.
- Writes buffered results to consecutive addresses of one SRAM write port.
- Reports completion of a vector operation to VPU_CONTROLLER.
- Sits between the ALU datapath (e.g. ISUB) and the SRAM write port.

---
 rtl/vpu_dst_port_pkg.sv | 18 +
 rtl/vpu_dst_fifo.sv | 57 +++++
 rtl/vpu_dst_port.sv | 121 ++++++++++++
 tb/tb_vpu_dst_port.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_dst_port_pkg.sv
// vpu_dst_port_pkg: shared widths and FSM state type for the VPU destination port.
// Rev 1.0
`default_nettype none

package vpu_dst_port_pkg;

  localparam int VPU_OPCODE_WIDTH    = 32;
  localparam int VPU_SRAM_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/vpu_dst_fifo.sv
// vpu_dst_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers.
// Rev 1.0
`default_nettype none

module vpu_dst_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic                  do_push;
  logic                  do_pop;

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vpu_dst_port.sv
// vpu_dst_port: buffers ALU results and streams them to consecutive SRAM addresses.
// Rev 1.0
`default_nettype none

module vpu_dst_port
  import vpu_dst_port_pkg::*;
#(
  parameter int OPCODE_WIDTH    = VPU_OPCODE_WIDTH,
  parameter int SRAM_ADDR_WIDTH = VPU_SRAM_ADDR_WIDTH,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [SRAM_ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [CNT_WIDTH-1:0]       elem_cnt_i,
  input  logic [OPCODE_WIDTH-1:0]    result_i,
  input  logic                       done_i,
  output logic                       wreq_o,
  output logic [SRAM_ADDR_WIDTH-1:0] waddr_o,
  output logic [OPCODE_WIDTH-1:0]    wdata_o,
  input  logic                       wready_i,
  output logic                       ready_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  state_t                     state;
  state_t                     state_next;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]       rem_in;
  logic [CNT_WIDTH-1:0]       rem_out;
  logic                       err;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CW-1:0]              fifo_count;
  logic [OPCODE_WIDTH-1:0]    fifo_head;

  logic start_ok;
  logic pop;
  logic take;
  logic push;
  logic overflow;
  logic out_dec;
  logic err_set;

  assign start_ok = (state == ST_IDLE) && start_i;
  assign pop      = wreq_o && wready_i;
  assign take     = (state == ST_RUN) && done_i && (rem_in != '0);
  assign push     = take && (!fifo_full || pop);
  // A dropped overflow result still retires one expected write so the op can finish.
  assign overflow = take && fifo_full && !pop;
  assign out_dec  = pop || overflow;
  assign err_set  = (done_i && !take) || overflow;

  vpu_dst_fifo #(
    .DATA_WIDTH (OPCODE_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (result_i),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start_i) state_next = (elem_cnt_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (out_dec && (rem_out == CNT_WIDTH'(1))) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      rem_in  <= '0;
      rem_out <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        addr_q  <= dst_addr_i;
        rem_in  <= elem_cnt_i;
        rem_out <= elem_cnt_i;
      end else begin
        if (take)    rem_in  <= rem_in - CNT_WIDTH'(1);
        if (pop)     addr_q  <= addr_q + SRAM_ADDR_WIDTH'(1);
        if (out_dec) rem_out <= rem_out - CNT_WIDTH'(1);
      end
      // A stray result in the same cycle as a new start still counts as an error.
      if (err_set)       err <= 1'b1;
      else if (start_ok) err <= 1'b0;
    end
  end

  assign wreq_o  = (state == ST_RUN) && !fifo_empty;
  assign waddr_o = addr_q;
  assign wdata_o = fifo_head;
  assign ready_o = (fifo_count < DEPTH_CNT);
  assign busy_o  = (state != ST_IDLE);
  assign done_o  = (state == ST_DONE);
  assign err_o   = err;

endmodule

`default_nettype wire

// File: tb/tb_vpu_dst_port.sv
// tb_vpu_dst_port: directed and random checks against a queue-based transaction model.
// Rev 1.0
`default_nettype none

module tb_vpu_dst_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [9:0]  dst_addr_i;
  logic [7:0]  elem_cnt_i;
  logic [31:0] result_i;
  logic        done_i;
  logic        wreq_o;
  logic [9:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        wready_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 clk = ~clk;

  vpu_dst_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .dst_addr_i (dst_addr_i),
    .elem_cnt_i (elem_cnt_i),
    .result_i   (result_i),
    .done_i     (done_i),
    .wreq_o     (wreq_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .wready_i   (wready_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Model: an op is a phase, a next write address, two element budgets and
  // a queue of results waiting to be written.
  int          m_phase;
  int          m_addr;
  int          m_left_in;
  int          m_left_out;
  logic [31:0] q[$];
  bit          m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase    = P_IDLE;
    m_addr     = 0;
    m_left_in  = 0;
    m_left_out = 0;
    m_err      = 1'b0;
    q.delete();
  endtask

  task automatic model_step();
    bit          xfer;
    bit          set_err;
    logic [31:0] tmp;
    xfer    = (m_phase == P_RUN) && (q.size() > 0) && wready_i;
    set_err = 1'b0;
    case (m_phase)
      P_IDLE: begin
        if (start_i) begin
          m_addr     = int'(dst_addr_i);
          m_left_in  = int'(elem_cnt_i);
          m_left_out = int'(elem_cnt_i);
          m_err      = 1'b0;
          m_phase    = (elem_cnt_i == 8'd0) ? P_DONE : P_RUN;
        end
        if (done_i) set_err = 1'b1;
      end
      P_RUN: begin
        if (done_i) begin
          if (m_left_in == 0) begin
            set_err = 1'b1;
          end else begin
            m_left_in--;
            if (q.size() < 4 || xfer) begin
              q.push_back(result_i);
            end else begin
              set_err = 1'b1;
              m_left_out--;
            end
          end
        end
        if (xfer) begin
          tmp    = q.pop_front();
          m_addr = (m_addr + 1) % 1024;
          m_left_out--;
          if (m_left_out == 0) m_phase = P_DONE;
        end
      end
      default: begin
        if (done_i) set_err = 1'b1;
        m_phase = P_IDLE;
      end
    endcase
    if (set_err) m_err = 1'b1;
  endtask

  task automatic check_outputs();
    bit ew;
    ew = (m_phase == P_RUN) && (q.size() > 0);
    chk("wreq_o",  wreq_o,  ew);
    chk("ready_o", ready_o, q.size() < 4);
    chk("busy_o",  busy_o,  m_phase != P_IDLE);
    chk("done_o",  done_o,  m_phase == P_DONE);
    chk("err_o",   err_o,   m_err);
    if (ew) begin
      chk("waddr_o", waddr_o, m_addr);
      chk("wdata_o", wdata_o, q[0]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic cyc(input bit st, input bit dn, input logic [31:0] res, input bit wr);
    start_i  = st;
    done_i   = dn;
    result_i = res;
    wready_i = wr;
    tick();
  endtask

  task automatic start_op(input int addr, input int cnt);
    dst_addr_i = addr[9:0];
    elem_cnt_i = cnt[7:0];
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    int  k;
    int  addr;
    int  cnt;
    bit  dn;

    rst_n      = 1'b0;
    start_i    = 1'b0;
    dst_addr_i = '0;
    elem_cnt_i = '0;
    result_i   = '0;
    done_i     = 1'b0;
    wready_i   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_waddr", waddr_o, 0);
    chk("reset_wdata", wdata_o, 0);
    rst_n = 1'b1;

    // Basic three-element op
    start_op(32'h010, 3);
    cyc(0, 1, 32'd5, 1);
    cyc(0, 1, 32'd7, 1);
    cyc(0, 1, 32'd9, 1);
    repeat (4) cyc(0, 0, 0, 1);
    chk("case1_err", err_o, 0);

    // Fill the buffer with the SRAM stalled, then drain
    start_op(32'h100, 6);
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h100 + i, 0);
    chk("full_ready", ready_o, 0);
    repeat (6) cyc(0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h200, 1);
    cyc(0, 1, 32'h201, 1);
    repeat (4) cyc(0, 0, 0, 1);

    // Overflow: fifth result arrives while full with no pop
    start_op(32'h200, 6);
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h300 + i, 0);
    cyc(0, 1, 32'hDEAD, 0);
    chk("overflow_err", err_o, 1);
    repeat (5) cyc(0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h55, 1);
    repeat (4) cyc(0, 0, 0, 1);

    // Zero-length op, then a stray result while idle
    start_op(32'h050, 0);
    chk("zero_done", done_o, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 32'hAA, 1);
    chk("idle_err", err_o, 1);
    repeat (2) cyc(0, 0, 0, 1);

    // Address wrap
    start_op(32'h3FF, 2);
    cyc(0, 1, 32'h11, 1);
    cyc(0, 1, 32'h22, 1);
    repeat (4) cyc(0, 0, 0, 1);

    // Reset with two entries buffered
    start_op(32'h020, 4);
    cyc(0, 1, 32'h1, 0);
    cyc(0, 1, 32'h2, 0);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("midrst_waddr", waddr_o, 0);
    chk("midrst_wdata", wdata_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) cyc(0, 0, 0, 1);
    start_op(32'h010, 3);
    cyc(0, 1, 32'd5, 1);
    cyc(0, 1, 32'd7, 1);
    cyc(0, 1, 32'd9, 1);
    repeat (4) cyc(0, 0, 0, 1);

    // Random ops with random SRAM back-pressure and occasional stray results
    for (int op = 0; op < 30; op++) begin
      addr = int'($urandom_range(0, 1023));
      cnt  = int'($urandom_range(0, 9));
      start_op(addr, cnt);
      k = 0;
      while (m_phase != P_IDLE && k < 300) begin
        dn = 1'b0;
        if (m_phase == P_RUN && m_left_in > 0 && q.size() < 4 && $urandom_range(0, 1) == 1)
          dn = 1'b1;
        else if ($urandom_range(0, 31) == 0)
          dn = 1'b1;
        cyc(0, dn, $urandom, $urandom_range(0, 3) != 0);
        k++;
      end
      chk("op_timeout", k < 300, 1);
      cyc(0, 0, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
